line_window_buffer: RTL and testbench

- Streaming successor to frame_buffer: accepts a raster-order pixel stream and holds the previous P_ROWS-1 image rows in circular line memories.
- For every pixel accepted from row P_ROWS-1 onward, emits a vertical strip of P_ROWS pixels at that column: oldest row to incoming row.
- Sits between the colorspace stage and the edge-detection kernel, with valid/ready on both sides.

---
 rtl/edge_pkg.sv | 39 +++
 rtl/line_ram.sv | 41 ++++
 rtl/line_window_buffer.sv | 229 ++++++++++++++++++++++
 tb/tb_line_window_buffer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// -----------------------------------------------------------------------------
// edge_pkg
// Shared types and defaults for the edge-detection front end (frame_buffer,
// line_window_buffer). Holds the default frame geometry, the pixel type, the
// line-window FSM state encoding and a small modular-index helper.
// No ports (package).
// -----------------------------------------------------------------------------
package edge_pkg;

  // Default frame geometry shared with frame_buffer.
  localparam int DEF_COLUMNS     = 640;
  localparam int DEF_FRAME_ROWS  = 480;
  localparam int DEF_ROWS        = 3;
  localparam int DEF_PIXEL_DEPTH = 8;

  typedef logic [DEF_PIXEL_DEPTH-1:0] pixel_t;

  // S_PRIME: line memories are being filled, no strips are produced.
  // S_STREAM: every accepted pixel produces one strip.
  typedef enum logic {
    S_PRIME  = 1'b0,
    S_STREAM = 1'b1
  } lwb_state_t;

  // (base + offset) mod modulus, valid for base < modulus and offset < modulus.
  // Avoids a general divider when rotating the line-memory index.
  function automatic int unsigned wrap_idx(input int unsigned base,
                                           input int unsigned offset,
                                           input int unsigned modulus);
    int unsigned sum;
    sum = base + offset;
    if (sum >= modulus) begin
      return sum - modulus;
    end else begin
      return sum;
    end
  endfunction

endpackage : edge_pkg

// File: rtl/line_ram.sv
// -----------------------------------------------------------------------------
// line_ram
// One image row of storage: P_COLUMNS entries of P_PIXEL_DEPTH bits, one
// synchronous write port and an asynchronous read port sharing one address.
// A read in the same cycle as a write to the same address returns the old
// contents (read-before-write), which the line window relies on.
// Ports:
//   clk_i    clock
//   we_i     write enable
//   addr_i   column address (read and write)
//   wdata_i  pixel to store
//   rdata_o  stored pixel at addr_i (combinational)
// -----------------------------------------------------------------------------
module line_ram
  import edge_pkg::*;
#(
  parameter int P_COLUMNS     = DEF_COLUMNS,
  parameter int P_PIXEL_DEPTH = DEF_PIXEL_DEPTH,
  localparam int AW           = $clog2(P_COLUMNS)
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [AW-1:0]            addr_i,
  input  logic [P_PIXEL_DEPTH-1:0] wdata_i,
  output logic [P_PIXEL_DEPTH-1:0] rdata_o
);

  // Contents are deliberately not reset; the window FSM never exposes
  // entries that were not written during the current frame.
  logic [P_PIXEL_DEPTH-1:0] mem_q [P_COLUMNS];

  // Row storage write port.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule : line_ram

// File: rtl/line_window_buffer.sv
// -----------------------------------------------------------------------------
// line_window_buffer
// Accepts a raster-order pixel stream and keeps the previous P_ROWS-1 rows in
// circular line memories. From row P_ROWS-1 of each frame onward, every
// accepted pixel yields a vertical strip of P_ROWS pixels at its column,
// registered with a latency of one cycle.
// Ports:
//   I_CLK, I_RESET_N  clock, asynchronous active-low reset
//   I_ENABLE          0 freezes the block (a pending strip may still drain)
//   I_PIXEL, I_VALID  input pixel stream, I_FRAME_START marks col 0 / row 0
//   O_READY           block can accept a pixel this cycle
//   O_STRIP           strip, low slice = incoming row, top slice = oldest row
//   O_COL, O_ROW      column and newest-row index of the strip
//   O_FRAME_END       strip is the last of its frame
//   O_VALID, I_READY  output handshake
// -----------------------------------------------------------------------------
module line_window_buffer
  import edge_pkg::*;
#(
  parameter int P_COLUMNS     = DEF_COLUMNS,
  parameter int P_ROWS        = DEF_ROWS,
  parameter int P_FRAME_ROWS  = DEF_FRAME_ROWS,
  parameter int P_PIXEL_DEPTH = DEF_PIXEL_DEPTH,
  localparam int CW           = $clog2(P_COLUMNS),
  localparam int RW           = $clog2(P_FRAME_ROWS),
  localparam int SW           = P_ROWS * P_PIXEL_DEPTH
) (
  input  logic                     I_CLK,
  input  logic                     I_RESET_N,
  input  logic                     I_ENABLE,
  input  logic [P_PIXEL_DEPTH-1:0] I_PIXEL,
  input  logic                     I_VALID,
  input  logic                     I_FRAME_START,
  output logic                     O_READY,
  output logic [SW-1:0]            O_STRIP,
  output logic [CW-1:0]            O_COL,
  output logic [RW-1:0]            O_ROW,
  output logic                     O_FRAME_END,
  output logic                     O_VALID,
  input  logic                     I_READY
);

  localparam int NMEM = P_ROWS - 1;
  localparam int WPW  = (NMEM > 1) ? $clog2(NMEM) : 1;

  localparam logic [CW-1:0]  COL_LAST       = CW'(P_COLUMNS - 1);
  localparam logic [RW-1:0]  ROW_LAST       = RW'(P_FRAME_ROWS - 1);
  localparam logic [RW-1:0]  ROW_PRIME_LAST = RW'(P_ROWS - 2);
  localparam logic [WPW-1:0] WP_LAST        = WPW'(NMEM - 1);

  // Position / FSM state.
  lwb_state_t     state_q, state_d;
  logic [CW-1:0]  col_q, col_d;
  logic [RW-1:0]  row_q, row_d;
  logic [WPW-1:0] wp_q, wp_d;

  // Registered output stage.
  logic           valid_q, valid_d;
  logic           frame_end_q, frame_end_d;
  logic [SW-1:0]  strip_q, strip_d;
  logic [CW-1:0]  ocol_q, ocol_d;
  logic [RW-1:0]  orow_q, orow_d;

  // Position of the pixel being offered, after I_FRAME_START override.
  lwb_state_t     state_eff_s;
  logic [CW-1:0]  col_eff_s;
  logic [RW-1:0]  row_eff_s;
  logic [WPW-1:0] wp_eff_s;

  logic                     ready_s;
  logic                     accept_s;
  logic                     last_col_s;
  logic                     last_pix_s;
  logic [NMEM-1:0]          we_s;
  logic [P_PIXEL_DEPTH-1:0] rd_data_s [NMEM];
  logic [SW-1:0]            strip_s;

  // Reset gates ready so nothing is accepted while the block is held in reset.
  assign ready_s  = I_RESET_N & I_ENABLE & (~valid_q | I_READY);
  assign accept_s = I_VALID & ready_s;

  // A frame start restarts the position at col 0 / row 0 / pointer 0 and
  // re-enters priming; the accepted pixel itself is then handled normally.
  always_comb begin
    if (I_FRAME_START) begin
      state_eff_s = S_PRIME;
      col_eff_s   = '0;
      row_eff_s   = '0;
      wp_eff_s    = '0;
    end else begin
      state_eff_s = state_q;
      col_eff_s   = col_q;
      row_eff_s   = row_q;
      wp_eff_s    = wp_q;
    end
  end

  assign last_col_s = (col_eff_s == COL_LAST);
  assign last_pix_s = last_col_s & (row_eff_s == ROW_LAST);

  // Only the memory holding the oldest row is overwritten by the new pixel.
  always_comb begin
    we_s = '0;
    for (int m = 0; m < NMEM; m++) begin
      we_s[m] = accept_s & (wp_eff_s == WPW'(m));
    end
  end

  for (genvar g = 0; g < NMEM; g++) begin : g_line
    line_ram #(
      .P_COLUMNS    (P_COLUMNS),
      .P_PIXEL_DEPTH(P_PIXEL_DEPTH)
    ) u_line_ram (
      .clk_i  (I_CLK),
      .we_i   (we_s[g]),
      .addr_i (col_eff_s),
      .wdata_i(I_PIXEL),
      .rdata_o(rd_data_s[g])
    );
  end

  // Strip assembly: slice j (1..P_ROWS-1) comes from memory wp+(P_ROWS-1-j),
  // so the top slice is memory wp (oldest) and slice 1 is memory wp-1.
  always_comb begin : strip_build
    logic [WPW-1:0] sel;
    sel     = '0;
    strip_s = '0;
    strip_s[P_PIXEL_DEPTH-1:0] = I_PIXEL;
    for (int j = 1; j < P_ROWS; j++) begin
      sel = WPW'(wrap_idx(32'(wp_eff_s), 32'(P_ROWS - 1 - j), 32'(NMEM)));
      strip_s[j*P_PIXEL_DEPTH +: P_PIXEL_DEPTH] = rd_data_s[sel];
    end
  end

  // FSM and position counters: next state.
  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    wp_d    = wp_q;
    if (accept_s) begin
      if (last_col_s) begin
        col_d = '0;
        if (row_eff_s == ROW_LAST) begin
          row_d   = '0;
          wp_d    = '0;
          state_d = S_PRIME;
        end else begin
          row_d = row_eff_s + RW'(1);
          wp_d  = (wp_eff_s == WP_LAST) ? '0 : (wp_eff_s + WPW'(1));
          // Leaving priming once rows 0..P_ROWS-2 are all stored.
          case (state_eff_s)
            S_PRIME:  state_d = (row_eff_s == ROW_PRIME_LAST) ? S_STREAM : S_PRIME;
            S_STREAM: state_d = S_STREAM;
            default:  state_d = S_PRIME;
          endcase
        end
      end else begin
        col_d   = col_eff_s + CW'(1);
        row_d   = row_eff_s;
        wp_d    = wp_eff_s;
        state_d = state_eff_s;
      end
    end else begin
      state_d = state_q;
    end
  end

  // FSM and position counter registers.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      state_q <= S_PRIME;
      col_q   <= '0;
      row_q   <= '0;
      wp_q    <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      wp_q    <= wp_d;
    end
  end

  // Output stage next state: load on a streaming accept, otherwise drain on
  // handshake. A handshake and a new load in the same cycle keep valid high.
  always_comb begin
    valid_d     = valid_q;
    frame_end_d = frame_end_q;
    strip_d     = strip_q;
    ocol_d      = ocol_q;
    orow_d      = orow_q;
    if (accept_s && (state_eff_s == S_STREAM)) begin
      valid_d     = 1'b1;
      frame_end_d = last_pix_s;
      strip_d     = strip_s;
      ocol_d      = col_eff_s;
      orow_d      = row_eff_s;
    end else if (valid_q && I_READY) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Output stage registers.
  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      valid_q     <= 1'b0;
      frame_end_q <= 1'b0;
      strip_q     <= '0;
      ocol_q      <= '0;
      orow_q      <= '0;
    end else begin
      valid_q     <= valid_d;
      frame_end_q <= frame_end_d;
      strip_q     <= strip_d;
      ocol_q      <= ocol_d;
      orow_q      <= orow_d;
    end
  end

  assign O_READY     = ready_s;
  assign O_VALID     = valid_q;
  assign O_FRAME_END = frame_end_q;
  assign O_STRIP     = strip_q;
  assign O_COL       = ocol_q;
  assign O_ROW       = orow_q;

endmodule : line_window_buffer

// File: tb/tb_line_window_buffer.sv
// -----------------------------------------------------------------------------
// tb_line_window_buffer
// Directed bench for line_window_buffer. Instance A: 4 cols, 3-row strips,
// 4-row frames. Instance B: 4 cols, 5-row strips, 6-row frames (pointer wrap).
// Pixel value = row*16 + col throughout.
// -----------------------------------------------------------------------------
module tb_line_window_buffer;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] pix;
  logic       fs;
  logic       dn_rdy;
  logic       a_ivld;
  logic       b_ivld;

  logic        a_ordy, a_fe, a_ovld;
  logic [23:0] a_strip;
  logic [1:0]  a_col, a_row;

  logic        b_ordy, b_fe, b_ovld;
  logic [39:0] b_strip;
  logic [1:0]  b_col;
  logic [2:0]  b_row;

  int n_checks = 0;
  int n_fail   = 0;

  logic [28:0] cap_q [$];

  line_window_buffer #(
    .P_COLUMNS(4), .P_ROWS(3), .P_FRAME_ROWS(4), .P_PIXEL_DEPTH(8)
  ) u_dut_a (
    .I_CLK(clk), .I_RESET_N(rst_n), .I_ENABLE(en), .I_PIXEL(pix),
    .I_VALID(a_ivld), .I_FRAME_START(fs), .O_READY(a_ordy),
    .O_STRIP(a_strip), .O_COL(a_col), .O_ROW(a_row),
    .O_FRAME_END(a_fe), .O_VALID(a_ovld), .I_READY(dn_rdy)
  );

  line_window_buffer #(
    .P_COLUMNS(4), .P_ROWS(5), .P_FRAME_ROWS(6), .P_PIXEL_DEPTH(8)
  ) u_dut_b (
    .I_CLK(clk), .I_RESET_N(rst_n), .I_ENABLE(en), .I_PIXEL(pix),
    .I_VALID(b_ivld), .I_FRAME_START(fs), .O_READY(b_ordy),
    .O_STRIP(b_strip), .O_COL(b_col), .O_ROW(b_row),
    .O_FRAME_END(b_fe), .O_VALID(b_ovld), .I_READY(dn_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Record every completed output handshake of instance A.
  always @(negedge clk) begin
    if (rst_n && a_ovld && dn_rdy) begin
      cap_q.push_back({a_strip, a_col, a_row, a_fe});
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pv(input int r, input int c);
    return 8'(r * 16 + c);
  endfunction

  function automatic logic [28:0] exp_a(input int r, input int c);
    logic fe;
    fe = (r == 3) && (c == 3);
    return {pv(r - 2, c), pv(r - 1, c), pv(r, c), 2'(c), 2'(r), fe};
  endfunction

  function automatic logic [39:0] exp_b(input int r, input int c);
    return {pv(r - 4, c), pv(r - 3, c), pv(r - 2, c), pv(r - 1, c), pv(r, c)};
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Offer one pixel to instance A (sel=0) or B (sel=1) until it is accepted.
  task automatic push_pix(input bit sel, input logic [7:0] p, input logic f);
    int n;
    n   = 0;
    pix = p;
    fs  = f;
    if (sel) b_ivld = 1'b1;
    else     a_ivld = 1'b1;
    @(negedge clk);
    while (((sel ? b_ordy : a_ordy) !== 1'b1) && (n < 50)) begin
      @(negedge clk);
      n++;
    end
    if ((sel ? b_ordy : a_ordy) !== 1'b1) begin
      check_eq("accept_timeout", 64'(sel ? b_ordy : a_ordy), 64'd1);
    end
    @(posedge clk);
    #1;
    a_ivld = 1'b0;
    b_ivld = 1'b0;
    fs     = 1'b0;
  endtask

  // Compare the captured strips of one frame against rows 2..3 in raster order.
  task automatic check_frame(input string tag);
    int r;
    int c;
    check_eq({tag, "_count"}, 64'(cap_q.size()), 64'd8);
    for (int k = 0; (k < 8) && (k < cap_q.size()); k++) begin
      r = 2 + k / 4;
      c = k % 4;
      check_eq(tag, 64'(cap_q[k]), 64'(exp_a(r, c)));
    end
    cap_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n  = 1'b0;
    en     = 1'b1;
    pix    = 8'h00;
    fs     = 1'b0;
    dn_rdy = 1'b1;
    a_ivld = 1'b0;
    b_ivld = 1'b0;

    // Reset state.
    #2;
    check_eq("rst_valid", 64'(a_ovld), 64'd0);
    check_eq("rst_ready", 64'(a_ordy), 64'd0);
    check_eq("rst_strip", 64'(a_strip), 64'd0);
    #10;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame 1: priming latency, first and last strips.
    for (int i = 0; i < 16; i++) begin
      push_pix(1'b0, pv(i / 4, i % 4), i == 0);
      if (i < 8) check_eq("prime_no_valid", 64'(a_ovld), 64'd0);
      if (i == 8) begin
        check_eq("first_valid", 64'(a_ovld), 64'd1);
        check_eq("first_strip", 64'(a_strip), 64'h001020);
        check_eq("first_col", 64'(a_col), 64'd0);
        check_eq("first_row", 64'(a_row), 64'd2);
        check_eq("first_fe", 64'(a_fe), 64'd0);
      end
      if (i == 15) begin
        check_eq("last_strip", 64'(a_strip), 64'h132333);
        check_eq("last_col", 64'(a_col), 64'd3);
        check_eq("last_row", 64'(a_row), 64'd3);
        check_eq("last_fe", 64'(a_fe), 64'd1);
      end
    end
    idle(2);
    check_frame("frame1");

    // Frame 2: re-priming without frame start, backpressure mid-row 2.
    for (int i = 0; i < 16; i++) begin
      if (i == 10) begin
        dn_rdy = 1'b0;
        a_ivld = 1'b1;
        pix    = pv(2, 2);
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          check_eq("bp_ready_low", 64'(a_ordy), 64'd0);
          check_eq("bp_valid_hold", 64'(a_ovld), 64'd1);
          check_eq("bp_strip_hold", 64'(a_strip), 64'h011121);
        end
        @(posedge clk);
        #1;
        dn_rdy = 1'b1;
      end
      push_pix(1'b0, pv(i / 4, i % 4), 1'b0);
      if (i < 8) check_eq("reprime_no_valid", 64'(a_ovld), 64'd0);
    end
    idle(2);
    check_frame("frame2_bp");

    // Frame 3: restart on the 6th pixel.
    for (int i = 0; i < 5; i++) begin
      push_pix(1'b0, pv(i / 4, i % 4), i == 0);
    end
    check_eq("pre_restart_no_valid", 64'(a_ovld), 64'd0);
    for (int i = 0; i < 16; i++) begin
      push_pix(1'b0, pv(i / 4, i % 4), i == 0);
      if (i == 7) check_eq("restart_prime", 64'(a_ovld), 64'd0);
      if (i == 8) begin
        check_eq("restart_valid", 64'(a_ovld), 64'd1);
        check_eq("restart_strip", 64'(a_strip), 64'h001020);
        check_eq("restart_col", 64'(a_col), 64'd0);
        check_eq("restart_row", 64'(a_row), 64'd2);
      end
    end
    idle(2);
    check_frame("frame3_restart");

    // Frame 4: enable low for two cycles mid-row 2.
    for (int i = 0; i < 16; i++) begin
      if (i == 10) begin
        en     = 1'b0;
        a_ivld = 1'b1;
        pix    = pv(2, 2);
        @(negedge clk);
        check_eq("en_ready_low", 64'(a_ordy), 64'd0);
        check_eq("en_valid_pending", 64'(a_ovld), 64'd1);
        @(negedge clk);
        check_eq("en_ready_low2", 64'(a_ordy), 64'd0);
        check_eq("en_valid_drained", 64'(a_ovld), 64'd0);
        check_eq("en_strip_hold", 64'(a_strip), 64'h011121);
        @(posedge clk);
        #1;
        en = 1'b1;
      end
      push_pix(1'b0, pv(i / 4, i % 4), 1'b0);
    end
    idle(2);
    check_frame("frame4_en");

    // Frame 5: reset mid-row, then frame 6 without frame start.
    for (int i = 0; i < 10; i++) begin
      push_pix(1'b0, pv(i / 4, i % 4), i == 0);
    end
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", 64'(a_ovld), 64'd0);
    check_eq("mid_rst_strip", 64'(a_strip), 64'd0);
    check_eq("mid_rst_col", 64'(a_col), 64'd0);
    check_eq("mid_rst_row", 64'(a_row), 64'd0);
    check_eq("mid_rst_ready", 64'(a_ordy), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cap_q.delete();
    @(posedge clk);
    #1;
    for (int i = 0; i < 16; i++) begin
      push_pix(1'b0, pv(i / 4, i % 4), 1'b0);
    end
    idle(2);
    check_frame("frame6_post_rst");

    // Instance B: 5-row strips, pointer wraps modulo 4.
    for (int i = 0; i < 24; i++) begin
      push_pix(1'b1, pv(i / 4, i % 4), i == 0);
      if (i == 15) check_eq("b_prime_no_valid", 64'(b_ovld), 64'd0);
      if (i >= 16) begin
        check_eq("b_valid", 64'(b_ovld), 64'd1);
        check_eq("b_strip", 64'(b_strip), 64'(exp_b(i / 4, i % 4)));
        check_eq("b_pos", 64'({b_row, b_col}), 64'({3'(i / 4), 2'(i % 4)}));
      end
      if (i == 16) check_eq("b_row4_col0", 64'(b_strip), 64'h0010203040);
      if (i == 23) begin
        check_eq("b_row5_col3", 64'(b_strip), 64'h1323334353);
        check_eq("b_fe", 64'(b_fe), 64'd1);
      end
    end
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_line_window_buffer
